// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-port Avalon-MM arbiter in front of a single-port on-chip RAM
//
// Shares one byte-enabled RAM port (registered address, 1-cycle read latency)
// between requester m0 (CPU data master) and m1 (packet-buffer DMA).
// One transfer is granted per cycle. Read data is returned to the owner of the read.
//
// Ports
//   clk, reset_n          single clock, asynchronous active-low reset
//   mN_address/chipselect/read/write/byteenable/writedata   requester N inputs
//   mN_waitrequest        stall; a transfer is accepted when it is requested and waitrequest is low
//   mN_readdata/readdatavalid   read data is a pass-through of mem_readdata, qualified by the valid pulse
//   mem_*                 RAM port (mem_readdata is valid 1 cycle after the read address)
//   conflict_clr          synchronous clear of conflict_count
//   conflict_count        saturating count of cycles where both ports request
//
// Optional build macro ONCHIP_ARB_LOCK_EN adds m0_lock/m1_lock. A granted port
// that holds lock keeps the RAM for as long as it keeps both lock and request.
module onchip_mem_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int BE_W       = 4,
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_chipselect,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_chipselect,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
`ifdef ONCHIP_ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              conflict_clr,
   output logic [CNT_W-1:0]  conflict_count
);
   logic rq0, rq1, rd0, rd1, both, pick1, arb0, arb1, gnt0, gnt1;
   logic hold, hold_own, last_gnt, rd_pend, rd_own;
   assign rq0 = m0_chipselect & (m0_read | m0_write);
   assign rq1 = m1_chipselect & (m1_read | m1_write);
   // a simultaneous read+write is treated as a write only
   assign rd0 = m0_read & ~m0_write;
   assign rd1 = m1_read & ~m1_write;
   assign both = rq0 & rq1;
   // on a conflict m1 wins only in round-robin mode when m0 was the last winner
   assign pick1 = (FIXED_PRIO == 0) & ~last_gnt;
   assign arb1 = rq1 & (~rq0 | pick1);
   assign arb0 = rq0 & ~arb1;
`ifdef ONCHIP_ARB_LOCK_EN
   logic lock_act, lock_own;
   // lock persists only while the owner keeps both request and lock asserted
   assign hold = lock_act & (lock_own ? (rq1 & m1_lock) : (rq0 & m0_lock));
   assign hold_own = lock_own;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_act <= 1'b0;
         lock_own <= 1'b0;
      end else begin
         lock_act <= (gnt0 & m0_lock) | (gnt1 & m1_lock);
         lock_own <= gnt1;
      end
   end
`else
   assign hold = 1'b0;
   assign hold_own = 1'b0;
`endif
   assign gnt1 = hold ? hold_own : arb1;
   assign gnt0 = hold ? ~hold_own : arb0;
   // reset_n gates only the outputs so the flops never see it as data
   assign m0_waitrequest = ~reset_n | (rq0 & ~gnt0);
   assign m1_waitrequest = ~reset_n | (rq1 & ~gnt1);
   assign mem_chipselect = reset_n & (gnt0 | gnt1);
   assign mem_address    = gnt1 ? m1_address    : m0_address;
   assign mem_write      = gnt1 ? m1_write      : m0_write;
   assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
   assign m0_readdata = mem_readdata;
   assign m1_readdata = mem_readdata;
   assign m0_readdatavalid = rd_pend & ~rd_own;
   assign m1_readdatavalid = rd_pend & rd_own;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt       <= 1'b1;
         rd_pend        <= 1'b0;
         rd_own         <= 1'b0;
         conflict_count <= '0;
      end else begin
         // a locked cycle leaves round-robin history untouched
         if ((gnt0 | gnt1) & ~hold) last_gnt <= gnt1;
         rd_pend <= (gnt0 & rd0) | (gnt1 & rd1);
         rd_own  <= gnt1;
         conflict_count <= conflict_clr ? '0 :
                           (both & ~&conflict_count) ? conflict_count + 1'b1 : conflict_count;
      end
   end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed self-checking bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset_n, conflict_clr, ram_clr;
   logic [9:0]  m0_address, m1_address;
   logic        m0_chipselect, m0_read, m0_write, m1_chipselect, m1_read, m1_write;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [9:0]  mem_address;
   logic        mem_chipselect, mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata, mem_readdata;
   logic [15:0] conflict_count;
   logic        f_wait0, f_wait1, f_rdv0, f_rdv1, f_cs, f_we;
   logic [31:0] f_rdata0, f_rdata1, f_wdata;
   logic [9:0]  f_addr;
   logic [3:0]  f_be;
   logic [1:0]  f_count;
`ifdef ONCHIP_ARB_LOCK_EN
   logic        m0_lock, m1_lock;
`endif
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   onchip_mem_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_chipselect(m0_chipselect), .m0_read(m0_read),
      .m0_write(m0_write), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_chipselect(m1_chipselect), .m1_read(m1_read),
      .m1_write(m1_write), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
`ifdef ONCHIP_ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .conflict_clr(conflict_clr), .conflict_count(conflict_count)
   );

   onchip_mem_arbiter #(.FIXED_PRIO(1), .CNT_W(2)) dut_fix (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_chipselect(m0_chipselect), .m0_read(m0_read),
      .m0_write(m0_write), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(f_wait0), .m0_readdata(f_rdata0), .m0_readdatavalid(f_rdv0),
      .m1_address(m1_address), .m1_chipselect(m1_chipselect), .m1_read(m1_read),
      .m1_write(m1_write), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(f_wait1), .m1_readdata(f_rdata1), .m1_readdatavalid(f_rdv1),
`ifdef ONCHIP_ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .mem_address(f_addr), .mem_chipselect(f_cs), .mem_write(f_we),
      .mem_byteenable(f_be), .mem_writedata(f_wdata), .mem_readdata(mem_readdata),
      .conflict_clr(conflict_clr), .conflict_count(f_count)
   );

   // RAM model: unwritten words read back as C0DE0000 | address
   logic [31:0] ram [1024];
   logic        wr_flag [1024];
   logic [9:0]  addr_q;
   logic [31:0] merged;
   function automatic logic [31:0] word(input logic [9:0] a);
      return wr_flag[a] ? ram[a] : (32'hC0DE0000 | {22'd0, a});
   endfunction
   always_comb begin
      merged = word(mem_address);
      for (int b = 0; b < 4; b++) if (mem_byteenable[b]) merged[8*b +: 8] = mem_writedata[8*b +: 8];
   end
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 1024; i++) wr_flag[i] <= 1'b0;
      end else if (mem_chipselect) begin
         addr_q <= mem_address;
         if (mem_write) begin
            ram[mem_address] <= merged;
            wr_flag[mem_address] <= 1'b1;
         end
      end
   end
   assign mem_readdata = word(addr_q);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic cs, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] d);
      m0_chipselect = cs; m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
   endtask

   task automatic drv1(input logic cs, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] d);
      m1_chipselect = cs; m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
   endtask

   initial begin
      reset_n = 1'b0; ram_clr = 1'b1; conflict_clr = 1'b0;
      drv0(0, 0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0, 0);
`ifdef ONCHIP_ARB_LOCK_EN
      m0_lock = 1'b0; m1_lock = 1'b0;
`endif
      repeat (2) @(negedge clk);
      drv0(1, 1, 0, 10'h010, 4'hF, 0); drv1(1, 1, 0, 10'h020, 4'hF, 0);
      #1;
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_cnt", conflict_count, 0);
      chk("rst_rdv0", m0_readdatavalid, 0);
      chk("rst_rdv1", m1_readdatavalid, 0);
      @(negedge clk);
      reset_n = 1'b1; ram_clr = 1'b0;
      drv0(0, 0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0, 0);
      // m0 write, then m1 reads the same word
      @(negedge clk);
      drv0(1, 0, 1, 10'h005, 4'hF, 32'hDEADBEEF);
      #1;
      chk("w_wait0", m0_waitrequest, 0);
      chk("w_cs", mem_chipselect, 1);
      chk("w_we", mem_write, 1);
      chk("w_addr", mem_address, 10'h005);
      @(negedge clk);
      drv0(0, 0, 0, 0, 0, 0); drv1(1, 1, 0, 10'h005, 4'hF, 0);
      #1;
      chk("r_wait1", m1_waitrequest, 0);
      chk("w_no_rdv0", m0_readdatavalid, 0);
      @(negedge clk);
      drv1(0, 0, 0, 0, 0, 0);
      #1;
      chk("r_rdv1", m1_readdatavalid, 1);
      chk("r_data1", m1_readdata, 32'hDEADBEEF);
      chk("r_rdv0", m0_readdatavalid, 0);
      @(negedge clk);
      #1;
      chk("r_rdv1_off", m1_readdatavalid, 0);
      // both ports read every cycle; each holds its address until accepted
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drv0(1, 1, 0, 10'(16 + (k + 1) / 2), 4'hF, 0);
         drv1(1, 1, 0, 10'(32 + k / 2), 4'hF, 0);
         #1;
         chk("rr_wait0", m0_waitrequest, (k % 2 == 1));
         chk("rr_wait1", m1_waitrequest, (k % 2 == 0));
         if (k % 2 == 1) begin
            chk("rr_rdv0", m0_readdatavalid, 1);
            chk("rr_data0", m0_readdata, 32'hC0DE0000 | 32'(16 + (k - 1) / 2));
            chk("rr_nrdv1", m1_readdatavalid, 0);
         end else if (k > 0) begin
            chk("rr_rdv1", m1_readdatavalid, 1);
            chk("rr_data1", m1_readdata, 32'hC0DE0000 | 32'(32 + k / 2 - 1));
            chk("rr_nrdv0", m0_readdatavalid, 0);
         end
      end
      @(negedge clk);
      drv0(0, 0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0, 0);
      #1;
      chk("rr_last_rdv1", m1_readdatavalid, 1);
      chk("rr_last_data1", m1_readdata, 32'hC0DE0022);
      chk("rr_last_nrdv0", m0_readdatavalid, 0);
      chk("rr_cnt", conflict_count, 6);
      chk("fix_cnt_sat", f_count, 3);
      // byte-lane write, and read+write together acting as a write
      @(negedge clk);
      drv0(1, 0, 1, 10'h030, 4'hF, 32'h11223344);
      @(negedge clk);
      drv0(0, 0, 0, 0, 0, 0); drv1(1, 0, 1, 10'h030, 4'h2, 32'h0000AB00);
      @(negedge clk);
      drv1(0, 0, 0, 0, 0, 0); drv0(1, 1, 1, 10'h031, 4'hF, 32'h00000055);
      @(negedge clk);
      drv0(1, 1, 0, 10'h030, 4'hF, 0);
      #1;
      chk("rw_no_rdv0", m0_readdatavalid, 0);
      @(negedge clk);
      drv0(1, 1, 0, 10'h031, 4'hF, 0);
      #1;
      chk("be_rdv0", m0_readdatavalid, 1);
      chk("be_data0", m0_readdata, 32'h1122AB44);
      @(negedge clk);
      drv0(0, 0, 0, 0, 0, 0);
      #1;
      chk("rw_rdv0", m0_readdatavalid, 1);
      chk("rw_data0", m0_readdata, 32'h00000055);
      chk("be_cnt", conflict_count, 6);
      // clear wins over a same-cycle conflict
      @(negedge clk);
      drv0(1, 1, 0, 10'h040, 4'hF, 0); drv1(1, 1, 0, 10'h041, 4'hF, 0); conflict_clr = 1'b1;
      @(negedge clk);
      drv0(0, 0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0, 0); conflict_clr = 1'b0;
      #1;
      chk("clr_cnt", conflict_count, 0);
      chk("clr_fcnt", f_count, 0);
      // fixed priority: m0 wins every conflict, 2-bit counter saturates at 3
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drv0(1, 1, 0, 10'h050, 4'hF, 0); drv1(1, 1, 0, 10'h051, 4'hF, 0);
         #1;
         chk("fix_wait0", f_wait0, 0);
         chk("fix_wait1", f_wait1, 1);
         chk("fix_cnt", f_count, (k < 3) ? k : 3);
      end
      @(negedge clk);
      drv0(0, 0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0, 0);
      #1;
      chk("fix_cnt_hold", f_count, 3);
      @(negedge clk);
      conflict_clr = 1'b1;
      @(negedge clk);
      conflict_clr = 1'b0;
      #1;
      chk("fix_cnt_clr", f_count, 0);
      // reset while a read is in flight
      @(negedge clk);
      drv0(1, 1, 0, 10'h010, 4'hF, 0);
      @(negedge clk);
      reset_n = 1'b0;
      drv1(1, 1, 0, 10'h020, 4'hF, 0);
      #1;
      chk("mid_rdv0", m0_readdatavalid, 0);
      chk("mid_wait0", m0_waitrequest, 1);
      chk("mid_wait1", m1_waitrequest, 1);
      chk("mid_cs", mem_chipselect, 0);
      @(negedge clk);
      reset_n = 1'b1;
      drv0(0, 0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0, 0);
      #1;
      chk("post_rdv0a", m0_readdatavalid, 0);
      @(negedge clk);
      #1;
      chk("post_rdv0b", m0_readdatavalid, 0);
      @(negedge clk);
      drv0(1, 1, 0, 10'h010, 4'hF, 0); drv1(1, 1, 0, 10'h020, 4'hF, 0);
      #1;
      chk("post_first_wait0", m0_waitrequest, 0);
      chk("post_first_wait1", m1_waitrequest, 1);
`ifdef ONCHIP_ARB_LOCK_EN
      // m0 won last, so m1 wins the next conflict and locks for three reads
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drv1(1, 1, 0, 10'(32 + k), 4'hF, 0);
         m1_lock = (k < 3);
         #1;
         chk("lock_wait0", m0_waitrequest, (k < 3));
         chk("lock_wait1", m1_waitrequest, (k == 3));
      end
      @(negedge clk);
      m1_lock = 1'b0;
`endif
      @(negedge clk);
      drv0(0, 0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the 1024x32 single-port on-chip RAM (byte-enabled, address registered, output unregistered, so 1-cycle read latency).
- Lets the Nios data master (port m0) and the Ethernet packet-buffer DMA (port m1) share the one RAM port.
- Round-robin or fixed-priority grant, one transfer per cycle, read data routed back to the owner with readdatavalid.

Parameters:
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins a conflict
- CNT_W, 16, width of conflict counter

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- m0_address / m1_address  in  ADDR_W  requester word address
- m0_chipselect / m1_chipselect  in  1  requester select
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_byteenable / m1_byteenable  in  BE_W  write byte lanes
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  stall; transfer accepted when request & !waitrequest
- m0_readdata / m1_readdata  out  DATA_W  read data, qualified by readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid pulse
- mem_address  out  ADDR_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  from RAM, valid 1 cycle after read address
- conflict_clr  in  1  synchronous clear of conflict_count
- conflict_count  out  CNT_W  cycles with both ports requesting, saturating

Behaviour:
- Request: rq_i = mi_chipselect & (mi_read | mi_write). If read and write are both set, the write wins and the read is dropped (no readdatavalid).
- Grant (combinational): only one port requesting -> that port. Both requesting:
  - FIXED_PRIO=1 -> m0.
  - FIXED_PRIO=0 -> the port not in last_gnt register.
- mi_waitrequest = rq_i & ~gnt_i. While reset_n is low, both waitrequest = 1 and mem_chipselect = 0.
- RAM drive: mem_chipselect = |gnt; mem_address, mem_write, mem_byteenable and mem_writedata are muxed from the granted port; the mux selects m0 when idle.
- last_gnt: updates on every granted cycle to the winner. Reset value 1, so m0 wins the first conflict.
- Read return pipeline:
  - Accepted read sets rd_pend = 1 and rd_own = winner (registered).
  - Next cycle, mi_readdatavalid = rd_pend & (rd_own == i).
  - m0_readdata and m1_readdata both = mem_readdata (pass-through); consumers qualify with valid.
- Throughput and latency: one transfer per cycle sustained. Back-to-back reads from alternating ports return in order, each with 1-cycle latency. Write has zero latency (accepted cycle = RAM write cycle).
- conflict_count: +1 each cycle where rq_0 & rq_1, saturating at all-ones.
  - conflict_clr forces 0 next cycle and has priority over increment in the same cycle.
- Reset values: rd_pend = 0, rd_own = 0, last_gnt = 1, conflict_count = 0, both readdatavalid = 0.
- Reset asserted mid-read: pending readdatavalid is cancelled; none is emitted after reset release.

Optional Feature:
- Macro: ONCHIP_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock and m1_lock (1 bit).
  - If granted port i has mi_lock = 1 at acceptance, a lock register holds grant to i on following cycles while rq_i & mi_lock. The other port gets waitrequest = 1 even on conflict, and last_gnt does not change while locked.
  - Lock releases the first cycle port i deasserts lock or request. Normal arbitration resumes in that same cycle.
  - Reset clears the lock.
- Undefined: no lock ports, no lock register; pure per-cycle arbitration.

Test Plan:
- m0 write addr 0x005, data 0xDEADBEEF, be 0xF; next cycle m1 read 0x005 -> m1_readdatavalid one cycle later with 0xDEADBEEF; m0_readdatavalid stays 0.
- Both ports read every cycle for 6 cycles (m0 at 0x010.., m1 at 0x020..) -> grants alternate m0,m1,m0,...; each waitrequest is high on alternate cycles; conflict_count = 6; data returns in order to the correct owner.
- m1 write be = 0x2, data 0x0000AB00 to a word holding 0x11223344 -> a later read returns 0x1122AB44.
- FIXED_PRIO=1 with both requesting for 4 cycles -> m0 granted all 4, m1_waitrequest held 1; count saturation checked with CNT_W = 2 (reaches 3 and holds), and conflict_clr zeroes it.
- Issue m0 read, assert reset_n low the next cycle -> no readdatavalid, both waitrequest = 1 during reset; after release the first conflict goes to m0.
- ONCHIP_ARB_LOCK_EN: m1 locks for 3 reads while m0 requests -> m1 granted 3 consecutive cycles; m0 is granted the cycle m1_lock drops.
